// File: rtl/serializer_if.sv
// Word-in / bit-out bundle for the serializer: producer drives the word side, the serializer drives the serial side.
// The producer acts as master; the serializer attaches through the slave modport.
interface serializer_if #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
);
    logic [DATA_W-1:0] data_i;
    logic [MOD_W-1:0]  data_mod_i;
    logic              data_val_i;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              busy_o;

    modport master (
        output data_i, data_mod_i, data_val_i,
        input  ser_data_o, ser_data_val_o, busy_o
    );

    modport slave (
        input  data_i, data_mod_i, data_val_i,
        output ser_data_o, ser_data_val_o, busy_o
    );
endinterface

// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter; first bit one cycle after accept, N contiguous valid bits.
// busy_o stalls the producer; SERIALIZER_PRELOAD_EN adds a one-word holder for back-to-back words.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    serializer_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [MOD_W-1:0]  cnt_q;
    logic              ser_q;
    logic              ser_vld_q;

    logic              busy;
    logic              drop;
    logic              take;
    logic              last;
    logic              load;
    logic [DATA_W-1:0] src_dat;
    logic [MOD_W-1:0]  src_m1;

    // N-1 is simply mod-1 in MOD_W bits: mod==0 wraps to DATA_W-1.
    assign drop = (bus.data_mod_i == MOD_W'(1)) || (bus.data_mod_i == MOD_W'(2));
    assign take = bus.data_val_i && !busy && !drop;
    assign last = (state_q == SHIFT) && (cnt_q == '0);

`ifdef SERIALIZER_PRELOAD_EN
    logic              hold_vld_q;
    logic [DATA_W-1:0] hold_dat_q;
    logic [MOD_W-1:0]  hold_m1_q;
    logic              stash;

    assign busy    = hold_vld_q;
    assign src_dat = hold_vld_q ? hold_dat_q : bus.data_i;
    assign src_m1  = hold_vld_q ? hold_m1_q : (bus.data_mod_i - MOD_W'(1));
    assign load    = ((state_q == IDLE) && take) || (last && (hold_vld_q || take));
    assign stash   = take && (state_q == SHIFT) && !last;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            hold_vld_q <= 1'b0;
            hold_dat_q <= '0;
            hold_m1_q  <= '0;
        end else if (stash) begin
            hold_vld_q <= 1'b1;
            hold_dat_q <= bus.data_i;
            hold_m1_q  <= bus.data_mod_i - MOD_W'(1);
        end else if (last && hold_vld_q) begin
            hold_vld_q <= 1'b0;
        end
    end
`else
    assign busy    = (state_q == SHIFT);
    assign src_dat = bus.data_i;
    assign src_m1  = bus.data_mod_i - MOD_W'(1);
    assign load    = (state_q == IDLE) && take;
`endif

    // Output register carries the current bit; shreg_q holds the bits still to come.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ser_q     <= 1'b0;
            ser_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q   <= SHIFT;
                        ser_q     <= src_dat[DATA_W-1];
                        ser_vld_q <= 1'b1;
                        shreg_q   <= {src_dat[DATA_W-2:0], 1'b0};
                        cnt_q     <= src_m1;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        ser_q     <= src_dat[DATA_W-1];
                        ser_vld_q <= 1'b1;
                        shreg_q   <= {src_dat[DATA_W-2:0], 1'b0};
                        cnt_q     <= src_m1;
                    end else if (cnt_q == '0) begin
                        state_q   <= IDLE;
                        ser_q     <= 1'b0;
                        ser_vld_q <= 1'b0;
                    end else begin
                        ser_q     <= shreg_q[DATA_W-1];
                        shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                        cnt_q     <= cnt_q - MOD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ser_data_o     = ser_q;
    assign bus.ser_data_val_o = ser_vld_q;
    assign bus.busy_o         = busy;
endmodule

// File: tb/tb_serializer.sv
// Randomized scoreboard bench for serializer: words are expanded into an expected bit queue on accept,
// a negedge monitor pops and compares every valid serial bit.
module tb_serializer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Reference state: bits of the word on the wire still to send, plus a waiting word length.
    int   rem = 0;
    int   hold = 0;
    bit   expq[$];

    serializer_if #(.DATA_W(DW)) bus ();

    serializer #(.DATA_W(DW)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit busy_exp();
`ifdef SERIALIZER_PRELOAD_EN
        return hold > 0;
`else
        return rem > 0;
`endif
    endfunction

    function automatic void model_reset();
        rem  = 0;
        hold = 0;
        expq.delete();
    endfunction

    function automatic void model_step(input logic v, input logic [DW-1:0] d, input logic [3:0] m);
        int n;
        bit acc;
        n   = (m == 4'd0) ? DW : int'(m);
        acc = v && !busy_exp() && (n >= 3);
        if (rem > 0) rem--;
        if (rem == 0 && hold > 0) begin
            rem  = hold;
            hold = 0;
        end
        if (acc) begin
            for (int i = 0; i < n; i++) expq.push_back(d[DW-1-i]);
            if (rem == 0) rem = n;
            else hold = n;
        end
    endfunction

    // One clock: present inputs, let the edge happen, update the reference model.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [3:0] m);
        bus.data_val_i = v;
        bus.data_i     = d;
        bus.data_mod_i = m;
        @(posedge clk);
        if (!arst_n) model_reset();
        else model_step(v, d, m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 4'd0);
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            chk("busy", 32'(bus.busy_o), 32'(busy_exp()));
            chk("valid", 32'(bus.ser_data_val_o), 32'(rem > 0));
            if (bus.ser_data_val_o) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_bit at %0t: got a valid bit, expected none", $time);
                end else begin
                    chk("bit", 32'(bus.ser_data_o), 32'(expq.pop_front()));
                end
            end else begin
                chk("idle_zero", 32'(bus.ser_data_o), 32'd0);
            end
        end
    end

    initial begin
        bus.data_val_i = 1'b0;
        bus.data_i     = '0;
        bus.data_mod_i = '0;
        #1;
        chk("rst_val", 32'(bus.ser_data_val_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        idle(2);
        arst_n = 1'b1;
        idle(10);

        drive(1'b1, 16'hA5F0, 4'd0);
        idle(20);

        drive(1'b1, 16'hB800, 4'd5);
        idle(7);
        drive(1'b1, 16'hFFFF, 4'd1);
        drive(1'b1, 16'hFFFF, 4'd2);
        idle(3);

        drive(1'b1, 16'h8001, 4'd0);
        for (int i = 0; i < 17; i++) drive(1'b1, 16'hFFFF, 4'd0);
        idle(20);

        drive(1'b1, 16'hFFFF, 4'd0);
        idle(7);
        #1;
        arst_n = 1'b0;
        #1;
        chk("abort_val", 32'(bus.ser_data_val_o), 32'd0);
        chk("abort_bit", 32'(bus.ser_data_o), 32'd0);
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        model_reset();
        idle(2);
        arst_n = 1'b1;
        drive(1'b1, 16'hC000, 4'd3);
        idle(6);

`ifdef SERIALIZER_PRELOAD_EN
        drive(1'b1, 16'hAAAA, 4'd0);
        idle(2);
        drive(1'b1, 16'h5555, 4'd4);
        idle(25);
`endif

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 2) == 0), 16'($urandom), 4'($urandom_range(0, 15)));
        end
        idle(40);
        chk("drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
